// File: rtl/dice_display_driver.sv
// Dice result receiver: converts a 5-bit roll to BCD by sequential double-dabble
// and drives a time-multiplexed two-digit 7-segment display.
module dice_display_driver #(
   parameter int REFRESH_DIV = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       value_valid,
   input  logic [4:0] value,
   input  logic       twty_mode,
   output logic       ready,
   output logic       err,
   output logic [6:0] seg,
   output logic [1:0] digit_sel
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

   // Digit registers hold a 4-bit code; 0..9 are numerals, two extra codes for dash/blank.
   localparam logic [3:0] CODE_DASH  = 4'hA;
   localparam logic [3:0] CODE_BLANK = 4'hF;

   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

   state_t     state_reg, state_next;
   logic [2:0] iter_reg, iter_next;
   logic [4:0] bin_reg, bin_next;
   logic [7:0] bcd_reg, bcd_next;
   logic [4:0] value_reg, value_next;
   logic       mode_reg, mode_next;
   logic [3:0] ones_reg, ones_next;
   logic [3:0] tens_reg, tens_next;
   logic       err_reg, err_next;
   logic [CW-1:0] refresh_reg;
   logic [1:0]    digit_sel_reg;

   logic [7:0] bcd_adj;
   logic       in_range;
   logic [3:0] disp_code;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_adj
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
      end
   endgenerate

   assign in_range = (value_reg != 5'd0) &&
                     (mode_reg ? (value_reg <= 5'd20) : (value_reg <= 5'd6));

   always_comb begin
      state_next = state_reg;
      iter_next  = iter_reg;
      bin_next   = bin_reg;
      bcd_next   = bcd_reg;
      value_next = value_reg;
      mode_next  = mode_reg;
      ones_next  = ones_reg;
      tens_next  = tens_reg;
      err_next   = err_reg;
      ready      = 1'b0;
      case (state_reg)
         IDLE: begin
            ready = 1'b1;
            if (value_valid) begin
               value_next = value;
               mode_next  = twty_mode;
               bin_next   = value;
               bcd_next   = 8'd0;
               iter_next  = 3'd0;
               state_next = CONVERT;
            end
         end
         CONVERT: begin
            {bcd_next, bin_next} = {bcd_adj, bin_reg} << 1;
            iter_next = iter_reg + 3'd1;
            if (iter_reg == 3'd4) state_next = COMMIT;
         end
         COMMIT: begin
            if (in_range) begin
               err_next  = 1'b0;
               ones_next = bcd_reg[3:0];
               tens_next = (bcd_reg[7:4] == 4'd0 || !mode_reg) ? CODE_BLANK : bcd_reg[7:4];
            end else begin
               err_next  = 1'b1;
               ones_next = CODE_DASH;
               tens_next = CODE_DASH;
            end
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         iter_reg  <= 3'd0;
         bin_reg   <= 5'd0;
         bcd_reg   <= 8'd0;
         value_reg <= 5'd0;
         mode_reg  <= 1'b0;
         ones_reg  <= CODE_BLANK;
         tens_reg  <= CODE_BLANK;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         iter_reg  <= iter_next;
         bin_reg   <= bin_next;
         bcd_reg   <= bcd_next;
         value_reg <= value_next;
         mode_reg  <= mode_next;
         ones_reg  <= ones_next;
         tens_reg  <= tens_next;
         err_reg   <= err_next;
      end
   end

   // Refresh counter is independent of the FSM so the display never stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_reg   <= '0;
         digit_sel_reg <= 2'b01;
      end else if (refresh_reg == REFRESH_LAST) begin
         refresh_reg   <= '0;
         digit_sel_reg <= {digit_sel_reg[0], digit_sel_reg[1]};
      end else begin
         refresh_reg <= refresh_reg + 1'b1;
      end
   end

   assign disp_code = digit_sel_reg[1] ? tens_reg : ones_reg;

   always_comb begin
      seg = 7'h00;
      case (disp_code)
         4'd0:      seg = 7'h3F;
         4'd1:      seg = 7'h06;
         4'd2:      seg = 7'h5B;
         4'd3:      seg = 7'h4F;
         4'd4:      seg = 7'h66;
         4'd5:      seg = 7'h6D;
         4'd6:      seg = 7'h7D;
         4'd7:      seg = 7'h07;
         4'd8:      seg = 7'h7F;
         4'd9:      seg = 7'h6F;
         CODE_DASH: seg = 7'h40;
         default:   seg = 7'h00;
      endcase
   end

   assign err       = err_reg;
   assign digit_sel = digit_sel_reg;

endmodule

// File: tb/tb_dice_display_driver.sv
// Scoreboard bench for dice_display_driver: expected display pushed at each strobe,
// popped and compared once the block reports ready again.
module tb_dice_display_driver;

   localparam int RD = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       value_valid;
   logic [4:0] value;
   logic       twty_mode;
   logic       ready;
   logic       err;
   logic [6:0] seg;
   logic [1:0] digit_sel;

   typedef struct {
      logic [6:0] ones;
      logic [6:0] tens;
      logic       err;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   dice_display_driver #(.REFRESH_DIV(RD)) dut (
      .clk(clk), .rst(rst), .value_valid(value_valid), .value(value),
      .twty_mode(twty_mode), .ready(ready), .err(err), .seg(seg), .digit_sel(digit_sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] lut(input int d);
      case (d)
         0: lut = 7'h3F; 1: lut = 7'h06; 2: lut = 7'h5B; 3: lut = 7'h4F; 4: lut = 7'h66;
         5: lut = 7'h6D; 6: lut = 7'h7D; 7: lut = 7'h07; 8: lut = 7'h7F; default: lut = 7'h6F;
      endcase
   endfunction

   function automatic exp_t model(input int v, input logic m);
      exp_t e;
      int   lim = m ? 20 : 6;
      if (v < 1 || v > lim) begin
         e.ones = 7'h40; e.tens = 7'h40; e.err = 1'b1;
      end else begin
         e.ones = lut(v % 10);
         e.tens = (v / 10 == 0 || !m) ? 7'h00 : lut(v / 10);
         e.err  = 1'b0;
      end
      return e;
   endfunction

   // Watch the mux until both digit phases have been seen (bounded).
   task automatic read_digits(output logic [6:0] ones, output logic [6:0] tens);
      bit got_o = 0, got_t = 0;
      ones = 'x; tens = 'x;
      for (int c = 0; c < 4 * RD && !(got_o && got_t); c++) begin
         @(negedge clk);
         if (digit_sel == 2'b01) begin ones = seg; got_o = 1; end
         else if (digit_sel == 2'b10) begin tens = seg; got_t = 1; end
      end
      if (!(got_o && got_t)) check("mux_timeout", 0, 1);
   endtask

   task automatic send(input logic [4:0] v, input logic m, input int drop_at, input logic [4:0] drop_v);
      exp_t e;
      logic [6:0] o, t;
      @(negedge clk);
      value = v; twty_mode = m; value_valid = 1'b1;
      sb.push_back(model(int'(v), m));
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         value_valid = 1'b0;
         if (k == drop_at) begin value = drop_v; value_valid = 1'b1; end
         check($sformatf("ready_n%0d", k), ready, (k == 7));
      end
      if (sb.size() == 0) begin
         check("sb_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         check("err", err, e.err);
         read_digits(o, t);
         check("ones", o, e.ones);
         check("tens", t, e.tens);
         $display("xact value=%0d mode=%0d ones=%02h tens=%02h err=%0b", v, m, o, t, err);
      end
   endtask

   initial begin
      logic [6:0] o, t;
      rst = 1'b1; value_valid = 1'b0; value = '0; twty_mode = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_ready", ready, 1);
      check("rst_err", err, 0);
      check("rst_seg", seg, 7'h00);
      check("rst_sel", digit_sel, 2'b01);
      for (int k = 1; k <= 2 * RD; k++) begin
         @(negedge clk);
         check("idle_ready", ready, 1);
         check("idle_err", err, 0);
         check("idle_seg", seg, 7'h00);
         check($sformatf("idle_sel_c%0d", k), digit_sel, ((k / RD) % 2) ? 2'b10 : 2'b01);
      end
      $display("xact idle refresh cycles=%0d", 2 * RD);

      send(5'd17, 1'b1, 0, 5'd0);
      send(5'd20, 1'b1, 0, 5'd0);
      send(5'd5,  1'b0, 0, 5'd0);
      send(5'd0,  1'b1, 0, 5'd0);
      send(5'd7,  1'b0, 0, 5'd0);
      send(5'd21, 1'b1, 0, 5'd0);
      send(5'd3,  1'b0, 0, 5'd0);
      send(5'd31, 1'b1, 0, 5'd0);
      send(5'd12, 1'b1, 3, 5'd4);
      // The dropped strobe must not start a conversion afterwards.
      repeat (8) begin
         @(negedge clk);
         check("drop_ready", ready, 1);
      end
      send(5'd0, 1'b1, 0, 5'd0);

      // Reset in the middle of converting 9: no commit, display blanks, err clears.
      @(negedge clk);
      value = 5'd9; twty_mode = 1'b1; value_valid = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         value_valid = 1'b0;
         if (k < 3) check("rc_busy", ready, 0);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rc_sel", digit_sel, 2'b01);
      @(negedge clk);
      check("rc_ready", ready, 1);
      check("rc_err", err, 0);
      read_digits(o, t);
      check("rc_ones", o, 7'h00);
      check("rc_tens", t, 7'h00);
      check("rc_err2", err, 0);
      $display("xact reset-abort value=9 ones=%02h tens=%02h err=%0b", o, t, err);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dice_display_driver.md
Name: dice_display_driver

Overview:
- Receive end of the dice roller's result interface: accepts a 5-bit dice value plus mode flag, converts it to two BCD digits by sequential double-dabble, and drives a time-multiplexed two-digit 7-segment display.
- Sits between the roller core and the board LED/segment pins.
- Replaces raw binary LED output with a human-readable number.

Parameters:
- REFRESH_DIV, 1000, clk cycles each digit stays lit before the mux toggles; legal range >= 2. The counter width is derived as clog2(REFRESH_DIV).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- value_valid  input  1  single-cycle strobe: value/twty_mode are valid this cycle
- value  input  5  dice result, unsigned binary
- twty_mode  input  1  0 = d6 range 1..6, 1 = d20 range 1..20; sampled with value
- ready  output  1  block can accept a value this cycle
- err  output  1  last accepted value was out of range for its mode
- seg  output  7  {g,f,e,d,c,b,a}, active-high segments
- digit_sel  output  2  one-hot digit enable: 2'b01 = ones, 2'b10 = tens

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, and named rst.
- Reset values:
  - ready = 1, err = 0, seg = 7'h00 (blank).
  - digit_sel = 2'b01; refresh counter = 0.
  - Both digit registers hold the BLANK code.
  - FSM in IDLE.
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE:
  - ready = 1.
  - value_valid = 1 in cycle N accepts the value: capture value and twty_mode, clear the shift/BCD scratch, go to CONVERT.
- CONVERT:
  - Runs exactly 5 cycles, N+1..N+5, one double-dabble iteration per cycle.
  - Each iteration: add 3 to any BCD nibble >= 5, then shift left one bit.
  - The scratch is 8 bits of BCD plus the 5-bit shift register.
  - Move to COMMIT after the 5th iteration.
- COMMIT:
  - One cycle, N+6.
  - Range check: in range is 1..6 if twty_mode = 0, 1..20 if twty_mode = 1.
  - In range: err <= 0; ones <= BCD ones; tens <= BCD tens, or BLANK if tens = 0 or twty_mode = 0.
  - Out of range (includes 0): err <= 1; both digits <= DASH.
  - Return to IDLE.
  - The new display is visible from cycle N+7.
- ready:
  - ready = 0 in CONVERT and COMMIT, i.e. cycles N+1..N+6.
  - ready = 1 again in cycle N+7.
- value_valid while ready = 0 is ignored: no queuing, no effect on the current conversion.
- Display registers and err keep their old contents until COMMIT.
- Refresh mux:
  - The counter runs freely in all FSM states, 0..REFRESH_DIV-1.
  - On wrap, digit_sel toggles between 2'b01 and 2'b10.
  - First toggle occurs REFRESH_DIV cycles after reset release.
- seg is decoded combinationally from registered state: the digit register selected by digit_sel.
- Segment codes (hex):
  - Digits: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - DASH=40, BLANK=00.
- Widths: BCD tens never exceeds 3 for 5-bit input. A value of 31 converts correctly to 3/1 before the range check rejects it.
- Reset asserted during CONVERT or COMMIT:
  - Aborts the conversion; no partial commit.
  - All registers take their reset values on that edge.
  - ready = 1 on the first cycle after reset deasserts.
- value_valid in the same cycle as rst: ignored, reset wins.

Test Plan:
- Reset, then idle 2*REFRESH_DIV cycles:
  - ready = 1, err = 0, seg = 00 throughout.
  - digit_sel = 01, toggling to 10 at cycle REFRESH_DIV and back to 01 at 2*REFRESH_DIV.
- value = 17, twty_mode = 1, strobe at N:
  - ready = 0 over N+1..N+6, ready = 1 at N+7.
  - From N+7: ones seg = 07, tens seg = 06, err = 0.
- value = 20 with twty_mode = 1: tens = 5B, ones = 3F.
- value = 5 with twty_mode = 0: ones = 6D, tens = 00 (blank).
- Out-of-range cases, each giving both digits = 40 and err = 1:
  - value = 0, twty_mode = 1.
  - value = 7, twty_mode = 0.
  - value = 21, twty_mode = 1.
- A following value = 3, twty_mode = 0 clears err and shows ones 4F, tens 00.
- Busy and reset checks:
  - value = 12 accepted at N, then value = 4 strobed at N+3: display shows 12 at N+7 and 4 is dropped.
  - Separately, rst pulsed at N+3 during a conversion of 9: display blank, ready = 1 at the cycle after rst falls, err = 0.
